// File: rtl/wb_grf.sv
// Write-back stage: selects write-back data, updates the 32x32 register file,
// serves two bypassed D-stage read ports and emits a registered commit record.
module wb_grf #(
   parameter logic [1:0]  WD_ALU    = 2'd0,
   parameter logic [1:0]  WD_DM     = 2'd1,
   parameter logic [1:0]  WD_PC8    = 2'd2,
   parameter logic [31:0] PC_OFFSET = 32'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  WDSelW,
   input  logic        RFenW,
   input  logic [31:0] ALUOutW,
   input  logic [31:0] DMRDW,
   input  logic [4:0]  A3W,
   input  logic [31:0] PC8W,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic [31:0] WDW,
   output logic        commit_valid,
   output logic [31:0] commit_pc,
   output logic [4:0]  commit_addr,
   output logic [31:0] commit_data,
   output logic [31:0] commit_count
);

   logic [31:0] regs_q [32];
   logic        we;
   logic        sel_ok;

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] cnt_q, cnt_d;

   // Write-data mux; the reserved code yields zero and also blocks the write.
   always_comb begin
      WDW    = '0;
      sel_ok = 1'b1;
      case (WDSelW)
         WD_ALU:  WDW = ALUOutW;
         WD_DM:   WDW = DMRDW;
         WD_PC8:  WDW = PC8W;
         default: begin
            WDW    = '0;
            sel_ok = 1'b0;
         end
      endcase
   end

   assign we = RFenW && (A3W != 5'd0) && sel_ok;

   always_comb begin
      RD1 = '0;
      if (A1 != 5'd0) begin
         RD1 = (we && (A3W == A1)) ? WDW : regs_q[A1];
      end
   end

   always_comb begin
      RD2 = '0;
      if (A2 != 5'd0) begin
         RD2 = (we && (A3W == A2)) ? WDW : regs_q[A2];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[A3W] <= WDW;
      end
   end

   // Commit record holds its last payload when no write retires.
   always_comb begin
      valid_d = we;
      pc_d    = pc_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (we) begin
         pc_d   = PC8W - PC_OFFSET;
         addr_d = A3W;
         data_d = WDW;
         cnt_d  = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign commit_valid = valid_q;
   assign commit_pc    = pc_q;
   assign commit_addr  = addr_q;
   assign commit_data  = data_q;
   assign commit_count = cnt_q;

endmodule
